// File: rtl/odd_one_pkg.sv
`default_nettype none
// ============================================================================
// Module      : odd_one_pkg
// Description : Shared definitions for the streaming odd-one-out finder:
//               FSM state encodings and result error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package odd_one_pkg;

    // FSM state encoding (2-bit, legacy-compatible constants)
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Result error codes
    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_BAD_COUNT = 2'd1;
    localparam logic [1:0] ERR_NO_ODD    = 2'd2;

endpackage : odd_one_pkg
`default_nettype wire

// File: rtl/odd_one_buf.sv
`default_nettype none
// ============================================================================
// Module      : odd_one_buf
// Description : Simple dual-port RAM, DEPTH x WIDTH. Synchronous write,
//               registered read (read data valid one cycle after i_rd_en).
//               Contents are never reset.
// Ports       : clk                      - rising-edge clock
//               i_wr_en/i_wr_addr/i_wr_data - write port
//               i_rd_en/i_rd_addr          - read request
//               o_rd_data                  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module odd_one_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 255,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : odd_one_buf
`default_nettype wire

// File: rtl/odd_one_stream.sv
`default_nettype none
// ============================================================================
// Module      : odd_one_stream
// Description : Streams N words over a valid/ready handshake, XOR-reducing
//               them to the value seen an odd number of times. An optional
//               verify pass re-reads a stored copy and counts occurrences of
//               the result; the result is held under a valid/ack handshake.
// Ports       : clk, reset (async, active-high)
//               start, count, check_en - operation request (sampled in IDLE)
//               in_data, in_valid, in_ready - input stream
//               out_value, out_valid, out_ack, err_code - result handshake
//               busy - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module odd_one_stream
    import odd_one_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 255,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             check_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [1:0]       err_code,
    output logic             busy
);

    localparam int               ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_check_en;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic             r_rd_pend;
    logic [CNT_W-1:0] r_occ;
    logic [WIDTH-1:0] r_out_value;
    logic [1:0]       r_err_code;

    logic             w_beat;
    logic             w_last_beat;
    logic             w_rd_issue;
    logic             w_rd_match;
    logic             w_check_done;
    logic [CNT_W-1:0] w_occ_next;
    logic [WIDTH-1:0] w_rd_data;

    assign w_beat      = (r_state == LOAD) && in_valid;
    assign w_last_beat = w_beat && (r_wr_ptr == (r_count - c_ONE));

    // Reads are issued for rd_ptr = 0..count-1; the extra cycle at
    // rd_ptr == count only collects the final read's data.
    assign w_rd_issue   = (r_state == CHECK) && (r_rd_ptr != r_count);
    assign w_check_done = (r_state == CHECK) && (r_rd_ptr == r_count);
    assign w_rd_match   = r_rd_pend && (w_rd_data == r_out_value);
    assign w_occ_next   = r_occ + CNT_W'(w_rd_match);

    odd_one_buf #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_beat),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (in_data),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_check_en  <= 1'b0;
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_pend   <= 1'b0;
            r_occ       <= '0;
            r_out_value <= '0;
            r_err_code  <= ERR_OK;
        end else begin
            // Marks that the RAM output register holds fresh read data
            r_rd_pend <= w_rd_issue;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count    <= count;
                        r_check_en <= check_en;
                        if ((count == '0) || (count > c_DEPTH)) begin
                            r_out_value <= '0;
                            r_err_code  <= ERR_BAD_COUNT;
                            r_state     <= DONE;
                        end else begin
                            r_acc    <= '0;
                            r_wr_ptr <= '0;
                            r_state  <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (w_beat) begin
                        r_acc    <= r_acc ^ in_data;
                        r_wr_ptr <= r_wr_ptr + c_ONE;
                    end
                    if (w_last_beat) begin
                        r_out_value <= r_acc ^ in_data;
                        if (r_check_en) begin
                            r_rd_ptr <= '0;
                            r_occ    <= '0;
                            r_state  <= CHECK;
                        end else begin
                            r_err_code <= ERR_OK;
                            r_state    <= DONE;
                        end
                    end
                end

                CHECK: begin
                    r_occ <= w_occ_next;
                    if (w_rd_issue) begin
                        r_rd_ptr <= r_rd_ptr + c_ONE;
                    end
                    if (w_check_done) begin
                        // Candidate is confirmed only if it occurs an odd number of times
                        r_err_code <= w_occ_next[0] ? ERR_OK : ERR_NO_ODD;
                        r_state    <= DONE;
                    end
                end

                DONE: begin
                    if (out_ack) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_value = r_out_value;
    assign err_code  = r_err_code;

endmodule : odd_one_stream
`default_nettype wire

// File: tb/tb_odd_one_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_odd_one_stream
// Description : Directed self-checking testbench for odd_one_stream
//               (WIDTH=8, DEPTH=16) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_one_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             check_en = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_valid;
    logic             out_ack = 1'b0;
    logic [1:0]       err_code;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    odd_one_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .check_en  (check_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] cnt, input logic chk);
        count    = cnt;
        check_en = chk;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_ready_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Latency counted from the final beat's edge (that edge counts as 1)
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_tests++;
        if (out_value !== 8'd0) begin n_fail++; $display("FAIL reset_out_value: got %0d expected 0", out_value); end
        n_tests++;
        if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_ready: busy=%0b in_ready=%0b expected 0/0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_start(5'd5, 1'b0);
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_load_state: in_ready=%0b busy=%0b expected 1/1", in_ready, busy);
        end
        send_beat(8'd3);
        send_beat(8'd7);
        send_beat(8'd3);
        send_beat(8'd9);
        send_beat(8'd7);
        wait_valid(lat);
        n_tests++;
        if (lat !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected 1", lat); end
        n_tests++;
        if (out_value !== 8'd9) begin n_fail++; $display("FAIL basic_value: got %0d expected 9", out_value); end
        n_tests++;
        if (err_code !== 2'd0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", err_code); end
        do_ack();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack_idle: out_valid=%0b busy=%0b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_bad_count();
        logic [CNT_W-1:0] cnts [2];
        cnts[0] = 5'd0;
        cnts[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            do_start(cnts[i], 1'b0);
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bad_count_ready[%0d]: got %0b expected 0", cnts[i], in_ready); end
            n_tests++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bad_count_valid[%0d]: got %0b expected 1", cnts[i], out_valid); end
            n_tests++;
            if (err_code !== 2'd1) begin n_fail++; $display("FAIL bad_count_err[%0d]: got %0d expected 1", cnts[i], err_code); end
            n_tests++;
            if (out_value !== 8'd0) begin n_fail++; $display("FAIL bad_count_value[%0d]: got %0d expected 0", cnts[i], out_value); end
            do_ack();
        end
    endtask

    task automatic test_verify();
        int lat;
        do_start(5'd5, 1'b1);
        send_beat(8'd3);
        send_beat(8'd7);
        send_beat(8'd3);
        send_beat(8'd9);
        send_beat(8'd7);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL verify_check_state: in_ready=%0b out_valid=%0b busy=%0b expected 0/0/1",
                     in_ready, out_valid, busy);
        end
        wait_valid(lat);
        n_tests++;
        if (lat !== 7) begin n_fail++; $display("FAIL verify_latency: got %0d expected 7", lat); end
        n_tests++;
        if (out_value !== 8'd9) begin n_fail++; $display("FAIL verify_value: got %0d expected 9", out_value); end
        n_tests++;
        if (err_code !== 2'd0) begin n_fail++; $display("FAIL verify_err: got %0d expected 0", err_code); end
        do_ack();
    endtask

    task automatic test_no_odd();
        int lat;
        do_start(5'd4, 1'b1);
        send_beat(8'd4);
        send_beat(8'd4);
        send_beat(8'd6);
        send_beat(8'd6);
        wait_valid(lat);
        n_tests++;
        if (lat !== 6) begin n_fail++; $display("FAIL no_odd_latency: got %0d expected 6", lat); end
        n_tests++;
        if (out_value !== 8'd0) begin n_fail++; $display("FAIL no_odd_value: got %0d expected 0", out_value); end
        n_tests++;
        if (err_code !== 2'd2) begin n_fail++; $display("FAIL no_odd_err: got %0d expected 2", err_code); end
        do_ack();
    endtask

    task automatic test_gaps_ack();
        int lat;
        logic [WIDTH-1:0] data [5];
        data[0] = 8'd3; data[1] = 8'd7; data[2] = 8'd3; data[3] = 8'd9; data[4] = 8'd7;
        // Traffic while IDLE must be ignored
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        tick();
        in_valid = 1'b0;
        do_start(5'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_beat(data[i]);
            if (i < 4) begin
                in_data = 8'hEE;
                tick();
            end
        end
        // Traffic during CHECK must be ignored
        in_valid = 1'b1;
        in_data  = 8'h5A;
        wait_valid(lat);
        in_valid = 1'b0;
        in_data  = '0;
        n_tests++;
        if (out_value !== 8'd9 || err_code !== 2'd0) begin
            n_fail++; $display("FAIL gaps_result: value=%0d err=%0d expected 9/0", out_value, err_code);
        end
        for (int c = 0; c < 3; c++) begin
            start = (c == 1);
            count = 5'd2;
            check_en = 1'b0;
            tick();
            start = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || out_value !== 8'd9 || err_code !== 2'd0) begin
                n_fail++;
                $display("FAIL gaps_hold[%0d]: valid=%0b value=%0d err=%0d expected 1/9/0",
                         c, out_valid, out_value, err_code);
            end
        end
        out_ack = 1'b1;
        start   = 1'b1;
        count   = 5'd3;
        tick();
        out_ack = 1'b0;
        start   = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL gaps_start_ignored: out_valid=%0b busy=%0b expected 0/0", out_valid, busy);
        end
        do_start(5'd1, 1'b0);
        send_beat(8'd5);
        wait_valid(lat);
        n_tests++;
        if (lat !== 1 || out_value !== 8'd5 || err_code !== 2'd0) begin
            n_fail++; $display("FAIL gaps_restart: lat=%0d value=%0d err=%0d expected 1/5/0", lat, out_value, err_code);
        end
        do_ack();
    endtask

    task automatic test_near_full();
        int lat;
        // 15 words: 1..7 twice each with 0xA5 once in the middle
        do_start(5'd15, 1'b1);
        for (int i = 1; i <= 7; i++) send_beat(8'(i));
        send_beat(8'hA5);
        for (int i = 7; i >= 1; i--) send_beat(8'(i));
        wait_valid(lat);
        n_tests++;
        if (lat !== 17) begin n_fail++; $display("FAIL full_latency: got %0d expected 17", lat); end
        n_tests++;
        if (out_value !== 8'hA5 || err_code !== 2'd0) begin
            n_fail++; $display("FAIL full_result: value=%0h err=%0d expected a5/0", out_value, err_code);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        do_start(5'd5, 1'b0);
        send_beat(8'd3);
        send_beat(8'd7);
        reset = 1'b1;
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
            out_value !== 8'd0 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: valid=%0b ready=%0b busy=%0b value=%0d err=%0d expected all 0",
                     out_valid, in_ready, busy, out_value, err_code);
        end
        tick();
        reset = 1'b0;
        tick();
        do_start(5'd3, 1'b0);
        send_beat(8'd1);
        send_beat(8'd2);
        send_beat(8'd1);
        wait_valid(lat);
        n_tests++;
        if (lat !== 1 || out_value !== 8'd2 || err_code !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid_rerun: lat=%0d value=%0d err=%0d expected 1/2/0", lat, out_value, err_code);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_count();
        test_verify();
        test_no_odd();
        test_gaps_ack();
        test_near_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_odd_one_stream
`default_nettype wire
